// File: rtl/bp_nonsynth_retire_queue.sv
// bp_nonsynth_retire_queue: in-order retire buffer pairing commits with out-of-order writebacks
module bp_nonsynth_retire_queue #(
    parameter int vaddr_width_p = 39,
    parameter int els_p = 16,
    parameter int timeout_p = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     commit_v_i,
    output logic                     commit_ready_o,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic [31:0]              commit_instr_i,
    input  logic                     commit_trap_i,
    input  logic [63:0]              commit_cause_i,
    input  logic                     commit_iwb_i,
    input  logic                     commit_fwb_i,
    input  logic                     wb_v_i,
    input  logic                     wb_fp_i,
    input  logic [4:0]               wb_addr_i,
    input  logic [63:0]              wb_data_i,
    output logic                     retire_v_o,
    input  logic                     retire_yumi_i,
    output logic [vaddr_width_p-1:0] retire_pc_o,
    output logic [31:0]              retire_instr_o,
    output logic                     retire_trap_o,
    output logic [63:0]              retire_cause_o,
    output logic                     retire_wb_v_o,
    output logic                     retire_fp_o,
    output logic [63:0]              retire_data_o,
    output logic [63:0]              retire_cnt_o,
    output logic                     orphan_o,
    output logic                     timeout_o
);
    localparam int aw = $clog2(els_p);
    logic [aw:0]              head_r, tail_r;
    logic [vaddr_width_p-1:0] pc_r    [els_p];
    logic [31:0]              instr_r [els_p];
    logic [63:0]              cause_r [els_p];
    logic [63:0]              data_r  [els_p];
    logic                     trap_r  [els_p];
    logic                     wbv_r   [els_p];
    logic                     fp_r    [els_p];
    logic                     pend_r  [els_p];
    logic [31:0]              wait_r;
    logic [aw-1:0]            head_idx, tail_idx, match_idx, idx;
    logic                     full, empty, enq, pop, new_wbv, match_v, head_wait;
    assign head_idx       = head_r[aw-1:0];
    assign tail_idx       = tail_r[aw-1:0];
    assign empty          = head_r == tail_r;
    assign full           = (head_idx == tail_idx) & (head_r[aw] != tail_r[aw]);
    assign commit_ready_o = ~full;
    assign enq            = commit_v_i & ~full;
    assign new_wbv        = ~commit_trap_i & (commit_fwb_i | (commit_iwb_i & (commit_instr_i[11:7] != 5'd0)));
    assign head_wait      = ~empty & pend_r[head_idx];
    assign retire_v_o     = ~empty & ~pend_r[head_idx];
    assign pop            = retire_yumi_i & retire_v_o;
    assign retire_pc_o    = pc_r[head_idx];
    assign retire_instr_o = instr_r[head_idx];
    assign retire_trap_o  = trap_r[head_idx];
    assign retire_cause_o = cause_r[head_idx];
    assign retire_wb_v_o  = wbv_r[head_idx];
    assign retire_fp_o    = fp_r[head_idx];
    assign retire_data_o  = data_r[head_idx];
    // oldest pending entry for the written register wins; the entering commit is the youngest candidate
    always_comb begin
        match_v   = wb_v_i & enq & new_wbv & (commit_fwb_i == wb_fp_i) & (commit_instr_i[11:7] == wb_addr_i);
        match_idx = tail_idx;
        idx       = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            idx = head_idx + aw'(i);
            if (wb_v_i && pend_r[idx] && fp_r[idx] == wb_fp_i && instr_r[idx][11:7] == wb_addr_i) begin
                match_v   = 1'b1;
                match_idx = idx;
            end
        end
    end
    // entry storage, pointers, retire count and sticky error flags
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_r       <= '0;
            tail_r       <= '0;
            wait_r       <= '0;
            retire_cnt_o <= '0;
            orphan_o     <= 1'b0;
            timeout_o    <= 1'b0;
            for (int i = 0; i < els_p; i++) begin
                pc_r[i]    <= '0;
                instr_r[i] <= '0;
                cause_r[i] <= '0;
                data_r[i]  <= '0;
                trap_r[i]  <= 1'b0;
                wbv_r[i]   <= 1'b0;
                fp_r[i]    <= 1'b0;
                pend_r[i]  <= 1'b0;
            end
        end else begin
            if (enq) begin
                pc_r[tail_idx]    <= commit_pc_i;
                instr_r[tail_idx] <= commit_instr_i;
                cause_r[tail_idx] <= commit_cause_i;
                data_r[tail_idx]  <= '0;
                trap_r[tail_idx]  <= commit_trap_i;
                wbv_r[tail_idx]   <= new_wbv;
                fp_r[tail_idx]    <= commit_fwb_i;
                pend_r[tail_idx]  <= new_wbv;
                tail_r            <= tail_r + 1'b1;
            end
            if (match_v) begin
                data_r[match_idx] <= wb_data_i;
                pend_r[match_idx] <= 1'b0;
            end
            if (wb_v_i && !match_v)
                orphan_o <= 1'b1;
            if (pop) begin
                head_r <= head_r + 1'b1;
                if (!trap_r[head_idx])
                    retire_cnt_o <= retire_cnt_o + 64'd1;
            end
            wait_r <= head_wait ? wait_r + 32'd1 : '0;
            if (head_wait && wait_r == 32'(timeout_p - 1))
                timeout_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_nonsynth_retire_queue.sv
// tb_bp_nonsynth_retire_queue: directed stimulus with a scoreboard-driven retire monitor
module tb_bp_nonsynth_retire_queue;
    localparam int va = 39;
    typedef struct packed {
        logic [va-1:0] pc;
        logic [31:0]   instr;
        logic          trap;
        logic [63:0]   cause;
        logic          wbv;
        logic          fp;
        logic [63:0]   data;
    } rec_t;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          commit_v_i = 1'b0;
    logic          commit_ready_o;
    logic [va-1:0] commit_pc_i = '0;
    logic [31:0]   commit_instr_i = '0;
    logic          commit_trap_i = 1'b0;
    logic [63:0]   commit_cause_i = '0;
    logic          commit_iwb_i = 1'b0;
    logic          commit_fwb_i = 1'b0;
    logic          wb_v_i = 1'b0;
    logic          wb_fp_i = 1'b0;
    logic [4:0]    wb_addr_i = '0;
    logic [63:0]   wb_data_i = '0;
    logic          retire_v_o;
    logic          retire_yumi_i = 1'b0;
    logic [va-1:0] retire_pc_o;
    logic [31:0]   retire_instr_o;
    logic          retire_trap_o;
    logic [63:0]   retire_cause_o;
    logic          retire_wb_v_o;
    logic          retire_fp_o;
    logic [63:0]   retire_data_o;
    logic [63:0]   retire_cnt_o;
    logic          orphan_o;
    logic          timeout_o;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pops_allowed = 0;

    bp_nonsynth_retire_queue #(.vaddr_width_p(va), .els_p(16), .timeout_p(1024)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .commit_v_i(commit_v_i), .commit_ready_o(commit_ready_o),
        .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
        .commit_trap_i(commit_trap_i), .commit_cause_i(commit_cause_i),
        .commit_iwb_i(commit_iwb_i), .commit_fwb_i(commit_fwb_i),
        .wb_v_i(wb_v_i), .wb_fp_i(wb_fp_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .retire_v_o(retire_v_o), .retire_yumi_i(retire_yumi_i),
        .retire_pc_o(retire_pc_o), .retire_instr_o(retire_instr_o),
        .retire_trap_o(retire_trap_o), .retire_cause_o(retire_cause_o),
        .retire_wb_v_o(retire_wb_v_o), .retire_fp_o(retire_fp_o), .retire_data_o(retire_data_o),
        .retire_cnt_o(retire_cnt_o), .orphan_o(orphan_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [va-1:0] pc, input logic [4:0] rd, input logic trap,
                        input logic [63:0] cause, input logic wbv, input logic fp, input logic [63:0] data);
        rec_t r;
        r.pc = pc; r.instr = {20'h0, rd, 7'h13}; r.trap = trap; r.cause = cause;
        r.wbv = wbv; r.fp = fp; r.data = data;
        exp_q.push_back(r);
    endtask

    task automatic step(input logic cv, input logic [va-1:0] pc, input logic [4:0] rd, input logic trap,
                        input logic [63:0] cause, input logic iwb, input logic fwb,
                        input logic wv, input logic wfp, input logic [4:0] wa, input logic [63:0] wd);
        commit_v_i = cv; commit_pc_i = pc; commit_instr_i = {20'h0, rd, 7'h13};
        commit_trap_i = trap; commit_cause_i = cause; commit_iwb_i = iwb; commit_fwb_i = fwb;
        wb_v_i = wv; wb_fp_i = wfp; wb_addr_i = wa; wb_data_i = wd;
        @(posedge clk_i); #1;
        commit_v_i = 1'b0; wb_v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk_i);
            k++;
        end
        #1;
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    // monitor: pops a record whenever the DUT offers one and compares it to the oldest expectation
    initial begin
        forever begin
            @(negedge clk_i);
            retire_yumi_i = 1'b0;
            if (reset_i && retire_v_o && pops_allowed > 0) begin
                pops_allowed--;
                retire_yumi_i = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_record: got pc %h expected none", retire_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rec_pc", 64'(retire_pc_o), 64'(mon_e.pc));
                    check("rec_instr", 64'(retire_instr_o), 64'(mon_e.instr));
                    check("rec_trap", 64'(retire_trap_o), 64'(mon_e.trap));
                    check("rec_cause", retire_cause_o, mon_e.cause);
                    check("rec_wb_v", 64'(retire_wb_v_o), 64'(mon_e.wbv));
                    check("rec_fp", 64'(retire_fp_o), 64'(mon_e.fp));
                    check("rec_data", retire_data_o, mon_e.data);
                end
            end
        end
    end

    initial begin
        idle(3);
        check("rst_ready", 64'(commit_ready_o), 64'd1);
        check("rst_retire_v", 64'(retire_v_o), 64'd0);
        check("rst_cnt", retire_cnt_o, 64'd0);
        check("rst_orphan", 64'(orphan_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        reset_i = 1'b1;
        idle(1);
        pops_allowed = 1000000;

        // three commits, each with its writeback in the same cycle
        push(39'h80000000, 5'd5, 1'b0, 64'd0, 1'b1, 1'b0, 64'h11);
        step(1'b1, 39'h80000000, 5'd5, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 64'h11);
        check("same_cycle_wb_v", 64'(retire_v_o), 64'd1);
        push(39'h80000004, 5'd6, 1'b0, 64'd0, 1'b1, 1'b0, 64'h22);
        step(1'b1, 39'h80000004, 5'd6, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 64'h22);
        push(39'h80000008, 5'd7, 1'b0, 64'd0, 1'b1, 1'b0, 64'h33);
        step(1'b1, 39'h80000008, 5'd7, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 64'h33);
        drain();
        check("cnt_after_3", retire_cnt_o, 64'd3);

        // WAW on x5: writebacks fill older entries first
        push(39'h80000010, 5'd5, 1'b0, 64'd0, 1'b1, 1'b0, 64'hA);
        step(1'b1, 39'h80000010, 5'd5, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        push(39'h80000014, 5'd5, 1'b0, 64'd0, 1'b1, 1'b0, 64'hB);
        step(1'b1, 39'h80000014, 5'd5, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        idle(3);
        check("waw_pending_v", 64'(retire_v_o), 64'd0);
        step(1'b0, '0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 64'hA);
        check("waw_head_v", 64'(retire_v_o), 64'd1);
        step(1'b0, '0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 64'hB);
        drain();
        check("cnt_after_waw", retire_cnt_o, 64'd5);

        // FP and int rd=3 pending; int writeback must not complete the FP head
        push(39'h80000020, 5'd3, 1'b0, 64'd0, 1'b1, 1'b1, 64'h66);
        step(1'b1, 39'h80000020, 5'd3, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        push(39'h80000024, 5'd3, 1'b0, 64'd0, 1'b1, 1'b0, 64'h55);
        step(1'b1, 39'h80000024, 5'd3, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step(1'b0, '0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 64'h55);
        idle(3);
        check("fp_head_blocks", 64'(retire_v_o), 64'd0);
        step(1'b0, '0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 64'h66);
        check("fp_head_v", 64'(retire_v_o), 64'd1);
        drain();
        check("cnt_after_fp", retire_cnt_o, 64'd7);
        check("orphan_clear", 64'(orphan_o), 64'd0);

        // fill to full with the tail wrapping, then pop once
        pops_allowed = 0;
        for (int i = 0; i < 16; i++) begin
            push(39'h80001000 + 39'(4 * i), 5'd10, 1'b0, 64'd0, 1'b1, 1'b0, 64'h100 + 64'(i));
            step(1'b1, 39'h80001000 + 39'(4 * i), 5'd10, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 64'h100 + 64'(i));
        end
        check("full_ready", 64'(commit_ready_o), 64'd0);
        check("full_retire_v", 64'(retire_v_o), 64'd1);
        pops_allowed = 1;
        step(1'b1, 39'h80002000, 5'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        check("ready_after_pop", 64'(commit_ready_o), 64'd1);
        push(39'h80001040, 5'd10, 1'b0, 64'd0, 1'b1, 1'b0, 64'h110);
        step(1'b1, 39'h80001040, 5'd10, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 64'h110);
        pops_allowed = 1000000;
        drain();
        check("cnt_after_wrap", retire_cnt_o, 64'd24);

        // orphan writeback and a trap record
        step(1'b0, '0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 64'h99);
        check("orphan_set", 64'(orphan_o), 64'd1);
        push(39'h80000100, 5'd0, 1'b1, 64'h2, 1'b0, 1'b0, 64'd0);
        step(1'b1, 39'h80000100, 5'd0, 1'b1, 64'h2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        drain();
        check("cnt_after_trap", retire_cnt_o, 64'd24);
        check("orphan_sticky", 64'(orphan_o), 64'd1);

        // head waits on x12 long enough to time out
        check("timeout_clear", 64'(timeout_o), 64'd0);
        step(1'b1, 39'h80000200, 5'd12, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step(1'b1, 39'h80000204, 5'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        idle(1000);
        check("timeout_early", 64'(timeout_o), 64'd0);
        idle(40);
        check("timeout_set", 64'(timeout_o), 64'd1);
        check("timeout_blocked_v", 64'(retire_v_o), 64'd0);

        // asynchronous reset mid-queue discards everything
        #2;
        reset_i = 1'b0;
        #1;
        check("async_rst_v", 64'(retire_v_o), 64'd0);
        check("async_rst_ready", 64'(commit_ready_o), 64'd1);
        check("async_rst_cnt", retire_cnt_o, 64'd0);
        check("async_rst_orphan", 64'(orphan_o), 64'd0);
        check("async_rst_timeout", 64'(timeout_o), 64'd0);
        idle(2);
        reset_i = 1'b1;
        idle(1);
        push(39'h80000300, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        step(1'b1, 39'h80000300, 5'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        drain();
        check("cnt_after_reset", retire_cnt_o, 64'd1);
        idle(3);
        check("empty_at_end", 64'(retire_v_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_nonsynth_retire_queue.md
# bp_nonsynth_retire_queue

Non-synthesizable in-order retire buffer that sits directly upstream of the cosimulation/trace checker. It accepts commit events from the backend commit stage and out-of-order register writebacks (including late integer/FP writebacks), pairs each writeback with the oldest committed instruction still waiting on that register, and releases fully resolved retire records in program order over a valid/yumi interface. It also flags orphan writebacks and stalled heads, so the checker never blocks silently.

## Interface
- vaddr_width_p, 39, PC width
- els_p, 16, queue depth (power of two, ≥2)
- timeout_p, 1024, cycles a head may wait for its writeback before timeout_o sets
- clk_i  in  1  clock, all state on posedge
- reset_i  in  1  reset, asynchronous, active-low
- commit_v_i  in  1  commit event valid
- commit_ready_o  out  1  queue can accept (= not full)
- commit_pc_i  in  vaddr_width_p  committed PC
- commit_instr_i  in  32  instruction; rd = bits [11:7]
- commit_trap_i  in  1  event is exception/interrupt (no writeback)
- commit_cause_i  in  64  trap cause
- commit_iwb_i / commit_fwb_i  in  1 each  instruction writes integer / FP rd (mutually exclusive)
- wb_v_i  in  1  writeback valid
- wb_fp_i  in  1  1 = FP register file, 0 = integer
- wb_addr_i  in  5  register written
- wb_data_i  in  64  raw writeback data
- retire_v_o  out  1  head record complete and valid
- retire_yumi_i  in  1  consumer takes head; legal only when retire_v_o
- retire_pc_o, retire_instr_o, retire_trap_o, retire_cause_o  out  vaddr_width_p/32/1/64  head fields
- retire_wb_v_o, retire_fp_o, retire_data_o  out  1/1/64  head writeback summary
- retire_cnt_o  out  64  number of non-trap records popped
- orphan_o  out  1  sticky: writeback matched no pending entry
- timeout_o  out  1  sticky: head waited timeout_p cycles

## Operation
- Circular buffer, head/tail pointers of clog2(els_p)+1 bits (wrap bit distinguishes full/empty). Per entry: pc, instr, trap, cause, wb_v, fp, pending, data.
- Enqueue on commit_v_i & commit_ready_o. wb_v = ~trap & (fwb | (iwb & rd≠0)); pending = wb_v. Integer write to x0 and traps enqueue complete.
- Writeback match: among valid entries with pending=1, same fp, same rd, select the oldest (searching from head). Entry being enqueued in the same cycle is a candidate, as the youngest. Matched entry: data←wb_data_i, pending←0.
- No match: data dropped, orphan_o sets and stays set until reset.
- Incomplete entries with no writeback stay pending; later writebacks to the same register fill older entries first (WAW order preserved).
- retire_v_o = nonempty & ~head.pending; outputs driven from the head entry registers (no wb_i bypass).
- Pop on retire_yumi_i: head advances; retire_cnt_o increments unless head.trap. Yumi without retire_v_o is a protocol error: ignored.
- Timeout counter: increments while nonempty & head.pending; clears on pop or when head completes; timeout_o sets when count reaches timeout_p−1; sticky.

## Timing
- Reset (asserted low, asynchronous): pointers, counters, valid/pending bits, orphan_o, timeout_o, retire_cnt_o = 0; retire_v_o = 0; commit_ready_o = 1 after reset.
- No-writeback commit at cycle N → retire_v_o at N+1.
- Writeback completing head at cycle M → retire_v_o at M+1. Commit and matching writeback in the same cycle N → retire_v_o at N+1.
- Full: commit_ready_o = 0; no bypass even if yumi same cycle; ready returns cycle after pop.
- Simultaneous enqueue, writeback and pop all legal in one cycle; a writeback never matches the entry being popped (it is complete).
- Reset mid-operation discards all entries, including pending ones.

## Test plan
- Reset then 3 commits (pc 0x80000000/04/08, iwb, rd=5,6,7) with wb data 0x11,0x22,0x33 each same cycle → three records in order, data matches, retire_cnt_o=3.
- Two commits writing x5 (data pending), then wb x5=0xA, wb x5=0xB → first record 0xA, second 0xB; head completes cycle after first wb.
- Commit FP rd=3 and int rd=3 both pending; int wb 0x55 → only int entry fills; head (FP) blocks retire_v_o until FP wb 0x66.
- Fill 16 entries, no yumi → commit_ready_o=0; one yumi → ready=1 next cycle; wrap tail past index 15 with data intact.
- wb x9 with no pending entry → orphan_o=1, stays 1; trap commit cause 0x2 → record retire_trap_o=1, retire_cnt_o unchanged.
- Head pending 1024 cycles → timeout_o=1 at cycle 1023 of wait; reset_i low mid-queue → all outputs 0 asynchronously.
